// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-memory responder behind the core's MEM stage. Accepts one RV32I
//   load/store per valid/ready handshake. It waits a fixed LATENCY, then
//   returns a single-cycle response pulse. Byte/half/word accesses are
//   supported, with sign or zero extension on loads and byte-lane stores.
//   Misaligned accesses and illegal funct3 values are flagged on resp_err.
//
//   state | meaning
//   IDLE  | ready for a request (req_ready=1)
//   WAIT  | request latched, counting down the access latency
//   RESP  | one-cycle response pulse (resp_valid=1)
//
// Ports
//   clock, reset_n       rising-edge clock, async active-low reset
//   req_valid/req_ready  request handshake
//   req_write            1 = store, 0 = load
//   req_funct3           000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr             byte address (bits above the array index alias)
//   req_wdata            right-aligned store data
//   resp_valid           one-cycle response pulse
//   resp_rdata           extended load data; 0 for stores and errors; held
//   resp_err             misaligned or illegal request; held
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            lat_write;
  logic [2:0]      lat_funct3;
  logic [AW+1:0]   lat_addr;
  logic [31:0]     lat_wdata;
  logic [31:0]     mem [DEPTH];

  logic            accept, enter_resp, mem_we;
  logic            op_write;
  logic [2:0]      op_funct3;
  logic [AW+1:0]   op_addr;
  logic [31:0]     op_wdata;
  logic [AW-1:0]   word_idx;
  logic [1:0]      lane;
  logic [31:0]     rd_word, shifted, load_val, wdata_rep;
  logic [3:0]      wmask;
  logic            illegal, misalign, err_nxt;

  logic            unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];

  assign accept = req_valid && req_ready;

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == CW'(1)) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_RESP);
  end

  // With LATENCY=1 the array is accessed on the accept edge itself, so the
  // live request is used in IDLE and the latched copy otherwise.
  always_comb begin
    if (state == S_IDLE) begin
      op_write  = req_write;
      op_funct3 = req_funct3;
      op_addr   = req_addr[AW+1:0];
      op_wdata  = req_wdata;
    end else begin
      op_write  = lat_write;
      op_funct3 = lat_funct3;
      op_addr   = lat_addr;
      op_wdata  = lat_wdata;
    end
  end

  assign enter_resp = (state_nxt == S_RESP) && (state != S_RESP);

  always_comb begin
    word_idx = op_addr[AW+1:2];
    lane     = op_addr[1:0];
    rd_word  = mem[word_idx];
    shifted  = rd_word >> {lane, 3'b000};
    illegal  = (op_funct3 == 3'b011) || (op_funct3 == 3'b110) ||
               (op_funct3 == 3'b111) || (op_write && op_funct3[2]);
    misalign = ((op_funct3[1:0] == 2'b01) && lane[0]) ||
               ((op_funct3[1:0] == 2'b10) && (lane != 2'b00));
    err_nxt  = illegal || misalign;
    case (op_funct3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = shifted;
    endcase
    case (op_funct3[1:0])
      2'b00: begin
        wmask     = 4'b0001 << lane;
        wdata_rep = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        wmask     = 4'b0011 << lane;
        wdata_rep = {2{op_wdata[15:0]}};
      end
      default: begin
        wmask     = 4'b1111;
        wdata_rep = op_wdata;
      end
    endcase
  end

  // reset_n gating keeps a LATENCY=1 accept during reset from writing.
  assign mem_we = enter_resp && op_write && !err_nxt && reset_n;

  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      lat_write  <= 1'b0;
      lat_funct3 <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_write  <= req_write;
        lat_funct3 <= req_funct3;
        lat_addr   <= req_addr[AW+1:0];
        lat_wdata  <= req_wdata;
        cnt        <= CW'(LATENCY - 1);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 1'b1;
      end
      if (enter_resp) begin
        resp_err   <= err_nxt;
        resp_rdata <= (err_nxt || op_write) ? 32'd0 : load_val;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        vin = 1'b0;
  logic        sel_cur = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_valid0, req_valid1, req_ready0, req_ready1;
  logic        resp_valid0, resp_valid1, resp_err0, resp_err1;
  logic [31:0] resp_rdata0, resp_rdata1;
  logic        ready_s, valid_s, err_s;
  logic [31:0] rdata_s;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  // Byte-addressed reference image per DUT (index = addr mod 4*DEPTH)
  logic [7:0] mb [2][1024];

  always #5 clock = ~clock;

  assign req_valid0 = vin & ~sel_cur;
  assign req_valid1 = vin & sel_cur;

  always_comb begin
    ready_s = sel_cur ? req_ready1  : req_ready0;
    valid_s = sel_cur ? resp_valid1 : resp_valid0;
    err_s   = sel_cur ? resp_err1   : resp_err0;
    rdata_s = sel_cur ? resp_rdata1 : resp_rdata0;
  end

  data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut0 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid0), .resp_rdata(resp_rdata0),
    .resp_err(resp_err0));

  data_mem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid1), .resp_rdata(resp_rdata1),
    .resp_err(resp_err1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: access size from funct3, alignment by modulo, bytes assembled
  // little-endian, then extended. Stores update the byte image.
  function automatic void model(input logic sel, input logic wr, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    int size, base;
    logic bad;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    bad  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (wr && f3 >= 3'd4);
    er   = bad || ((addr % size) != 0);
    rd   = 32'd0;
    if (er) return;
    base = int'(addr % 1024);
    if (wr) begin
      for (int k = 0; k < size; k++) mb[sel][base + k] = wd[8*k +: 8];
    end else begin
      for (int k = 0; k < size; k++) rd = rd | (32'(mb[sel][base + k]) << (8 * k));
      if (f3 < 3'd4 && size < 4 && rd[8*size-1]) rd = rd | (32'hFFFF_FFFF << (8 * size));
    end
  endfunction

  task automatic do_req(input logic sel, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
    logic [31:0] erd;
    logic        eer;
    int          n, lat;
    bit          got;
    @(negedge clock);
    sel_cur = sel; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd; vin = 1'b1;
    n = 0;
    while (!ready_s && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk($sformatf("d%0d_ready_idle", sel), 32'(ready_s), 32'd1);
    model(sel, wr, f3, addr, wd, erd, eer);
    @(posedge clock);
    #1 vin = 1'b0;
    lat = 0;
    got = 0;
    while (!got && lat < 20) begin
      @(negedge clock);
      lat++;
      if (valid_s) got = 1;
      else chk($sformatf("d%0d_ready_low_wait", sel), 32'(ready_s), 32'd0);
    end
    chk($sformatf("d%0d_latency", sel), 32'(lat), sel ? 32'd1 : 32'd2);
    chk($sformatf("d%0d_ready_low_resp", sel), 32'(ready_s), 32'd0);
    chk($sformatf("d%0d_rdata a=%h f3=%0d w=%0d", sel, addr, f3, wr), rdata_s, erd);
    chk($sformatf("d%0d_err a=%h f3=%0d w=%0d", sel, addr, f3, wr), 32'(err_s), 32'(eer));
    rd = rdata_s;
    er = err_s;
    @(negedge clock);
    chk($sformatf("d%0d_pulse_end", sel), 32'(valid_s), 32'd0);
    chk($sformatf("d%0d_ready_back", sel), 32'(ready_s), 32'd1);
    chk($sformatf("d%0d_rdata_hold", sel), rdata_s, erd);
  endtask

  task automatic b2b(input logic sel);
    int          c, a1, a2, n;
    logic [31:0] erd;
    logic        eer;
    bit          acc, got;
    @(negedge clock);
    sel_cur = sel; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h400; req_wdata = 32'hA5A5_A5A5; vin = 1'b1;
    a1 = -1; a2 = -1; c = 0;
    while (a2 < 0 && c < 40) begin
      acc = ready_s;
      if (acc) begin
        if (a1 < 0) model(sel, 1'b1, 3'b010, 32'h400, 32'hA5A5_A5A5, erd, eer);
        else        model(sel, 1'b0, 3'b010, 32'h0, 32'h0, erd, eer);
      end
      @(posedge clock);
      #1;
      if (acc) begin
        if (a1 < 0) begin
          a1 = c;
          req_write = 1'b0;
          req_addr  = 32'h0;
        end else begin
          a2 = c;
          vin = 1'b0;
        end
      end
      c++;
      @(negedge clock);
    end
    chk($sformatf("d%0d_b2b_spacing", sel), 32'(a2 - a1), sel ? 32'd2 : 32'd3);
    n = 0;
    got = 0;
    while (!got && n < 10) begin
      if (valid_s) got = 1;
      else begin
        @(negedge clock);
        n++;
      end
    end
    chk($sformatf("d%0d_b2b_lat", sel), 32'(n), sel ? 32'd0 : 32'd1);
    chk($sformatf("d%0d_b2b_alias_model", sel), rdata_s, erd);
    chk($sformatf("d%0d_b2b_alias", sel), rdata_s, 32'hA5A5_A5A5);
    @(negedge clock);
  endtask

  initial begin
    logic [31:0] rd, a, hi;
    logic        er;
    logic [2:0]  f3;
    logic        wr;
    int          w, ln;

    #12;
    chk("rst_ready0", 32'(req_ready0), 32'd1);
    chk("rst_valid0", 32'(resp_valid0), 32'd0);
    chk("rst_rdata0", resp_rdata0, 32'd0);
    chk("rst_err0", 32'(resp_err0), 32'd0);
    chk("rst_ready1", 32'(req_ready1), 32'd1);
    chk("rst_valid1", 32'(resp_valid1), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 16; i++)
        do_req(s[0], 1'b1, 3'b010, 32'(i * 4), $urandom, rd, er);

    do_req(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, er);
    do_req(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    chk("t1_lw", rd, 32'hDEAD_BEEF);
    chk("t1_lw_err", 32'(er), 32'd0);
    do_req(1'b0, 1'b0, 3'b000, 32'h13, 32'h0, rd, er); chk("t2_lb", rd, 32'hFFFF_FFDE);
    do_req(1'b0, 1'b0, 3'b100, 32'h13, 32'h0, rd, er); chk("t2_lbu", rd, 32'h0000_00DE);
    do_req(1'b0, 1'b0, 3'b001, 32'h12, 32'h0, rd, er); chk("t2_lh", rd, 32'hFFFF_DEAD);
    do_req(1'b0, 1'b0, 3'b101, 32'h10, 32'h0, rd, er); chk("t2_lhu", rd, 32'h0000_BEEF);
    do_req(1'b0, 1'b1, 3'b000, 32'h11, 32'h55, rd, er);
    do_req(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er); chk("t3_sb", rd, 32'hDEAD_55EF);
    do_req(1'b0, 1'b1, 3'b001, 32'h12, 32'h1234, rd, er);
    do_req(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er); chk("t3_sh", rd, 32'h1234_55EF);
    do_req(1'b0, 1'b0, 3'b010, 32'h12, 32'h0, rd, er);
    chk("t4_lw_mis_err", 32'(er), 32'd1);
    chk("t4_lw_mis_rdata", rd, 32'd0);
    do_req(1'b0, 1'b1, 3'b001, 32'h11, 32'hFFFF, rd, er); chk("t4_sh_mis", 32'(er), 32'd1);
    do_req(1'b0, 1'b1, 3'b010, 32'h02, 32'hFFFF_FFFF, rd, er); chk("t4_sw_mis", 32'(er), 32'd1);
    do_req(1'b0, 1'b0, 3'b011, 32'h10, 32'h0, rd, er); chk("t4_f3_011", 32'(er), 32'd1);
    do_req(1'b0, 1'b1, 3'b100, 32'h10, 32'h0, rd, er); chk("t4_sbu", 32'(er), 32'd1);
    do_req(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, rd, er); chk("t4_unchanged", rd, 32'h1234_55EF);
    do_req(1'b0, 1'b0, 3'b010, 32'h00, 32'h0, rd, er);

    do_req(1'b0, 1'b1, 3'b010, 32'h20, 32'h1, rd, er);
    @(negedge clock);
    sel_cur = 1'b0; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'h2; vin = 1'b1;
    @(posedge clock);
    #1 vin = 1'b0;
    @(negedge clock);
    chk("t5_in_wait", 32'(req_ready0), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_ready", 32'(req_ready0), 32'd1);
    chk("t5_rst_valid", 32'(resp_valid0), 32'd0);
    @(negedge clock);
    chk("t5_rst_valid2", 32'(resp_valid0), 32'd0);
    chk("t5_rst_rdata", resp_rdata0, 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    chk("t5_no_resp", 32'(resp_valid0), 32'd0);
    do_req(1'b0, 1'b0, 3'b010, 32'h20, 32'h0, rd, er);
    chk("t5_lw_after_rst", rd, 32'h0000_0001);

    b2b(1'b0);
    b2b(1'b1);

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 40; i++) begin
        wr = 1'($urandom_range(0, 1));
        f3 = 3'($urandom_range(0, 7));
        w  = int'($urandom_range(0, 15));
        ln = int'($urandom_range(0, 3));
        hi = $urandom;
        a  = {hi[31:10], 4'b0000, 4'(w), 2'(ln)};
        do_req(s[0], wr, f3, a, $urandom, rd, er);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
